// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, types and the output clamp for the convolution
// MAC stage.
//   DEF_*      default widths used by conv_mac_stage3 / conv_tap_mac
//   pixel_t    unsigned output pixel
//   coef_t     signed kernel tap
//   acc_t      signed MAC accumulator
//   state_t    stage FSM encoding
//   clamp_pix  accumulator -> 8-bit pixel saturation
// Build option: CONV_ABS_EN makes clamp_pix saturate |acc| (edge magnitude)
// instead of flooring negative sums at 0.
package conv_pkg;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_COEF_W = 4;
  localparam int DEF_ACC_W  = 17;
  localparam int DEF_CNT_W  = 16;
  localparam int NTAP       = 9;
  localparam int TAP_W      = 4;

  typedef logic        [DEF_PIX_W-1:0]  pixel_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {IDLE, READY, MAC, OUT} state_t;

  localparam acc_t PIX_MAX = acc_t'((1 << DEF_PIX_W) - 1);

  function automatic pixel_t clamp_pix(input acc_t acc);
    acc_t a;
    a = acc;
`ifdef CONV_ABS_EN
    // most-negative acc is unreachable (9 bounded products), so negation is safe
    if (a[DEF_ACC_W-1]) a = -a;
`endif
    if (a[DEF_ACC_W-1])    clamp_pix = '0;
    else if (a > PIX_MAX)  clamp_pix = '1;
    else                   clamp_pix = a[DEF_PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_tap_mac.sv
// conv_tap_mac: one-tap-per-cycle multiply-accumulate.
//   clk, rst     clock, synchronous active-high reset
//   clr_i        zero the accumulator (window accept)
//   en_i         add product of selected tap into accumulator
//   tap_i        tap index 0..8
//   win_i        nine unsigned window pixels, [0] = top-left
//   kern_i       nine signed coefficients, same ordering
//   acc_o        registered accumulator
//   acc_nxt_o    accumulator plus current product (used to register the
//                clamped result on the same edge the last tap lands)
module conv_tap_mac
  import conv_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic                          en_i,
  input  logic [TAP_W-1:0]              tap_i,
  input  logic [NTAP-1:0][PIX_W-1:0]    win_i,
  input  logic [NTAP-1:0][COEF_W-1:0]   kern_i,
  output logic signed [ACC_W-1:0]       acc_o,
  output logic signed [ACC_W-1:0]       acc_nxt_o
);

  localparam int PW = PIX_W + COEF_W + 1;

  logic [PIX_W-1:0]        pix;
  logic [COEF_W-1:0]       coef;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q;

  assign pix  = win_i[tap_i];
  assign coef = kern_i[tap_i];

  // pixel zero-extended, coefficient sign-extended, both to product width;
  // the true product always fits PW bits
  assign prod = $signed({{(COEF_W+1){1'b0}}, pix}) *
                $signed({{(PIX_W+1){coef[COEF_W-1]}}, coef});

  assign acc_nxt_o = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign acc_o     = acc_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) acc_q <= '0;
    else if (en_i)    acc_q <= acc_nxt_o;
  end

endmodule

// File: rtl/conv_mac_stage3.sv
// conv_mac_stage3: kernel load, 3x3 window accept, 9-cycle sequential MAC,
// clamp to 8-bit pixel, output handshake.
//   clk, rst                   clock, synchronous active-high reset
//   stage3_start               load kernel (IDLE/READY only)
//   k_pixel_1..9               signed kernel taps, row-major
//   win_pixel_1..9             unsigned window pixels, row-major
//   in_valid / in_ready        window handshake (in_ready only in READY)
//   out_pixel / out_valid /    result handshake (valid only in OUT)
//   out_ready
//   busy                       MAC or OUT
//   pixel_count                completed output handshakes, wrapping
// Build option: CONV_ABS_EN (see conv_pkg::clamp_pix).
module conv_mac_stage3
  import conv_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stage3_start,
  input  logic [COEF_W-1:0] k_pixel_1,
  input  logic [COEF_W-1:0] k_pixel_2,
  input  logic [COEF_W-1:0] k_pixel_3,
  input  logic [COEF_W-1:0] k_pixel_4,
  input  logic [COEF_W-1:0] k_pixel_5,
  input  logic [COEF_W-1:0] k_pixel_6,
  input  logic [COEF_W-1:0] k_pixel_7,
  input  logic [COEF_W-1:0] k_pixel_8,
  input  logic [COEF_W-1:0] k_pixel_9,
  input  logic [PIX_W-1:0]  win_pixel_1,
  input  logic [PIX_W-1:0]  win_pixel_2,
  input  logic [PIX_W-1:0]  win_pixel_3,
  input  logic [PIX_W-1:0]  win_pixel_4,
  input  logic [PIX_W-1:0]  win_pixel_5,
  input  logic [PIX_W-1:0]  win_pixel_6,
  input  logic [PIX_W-1:0]  win_pixel_7,
  input  logic [PIX_W-1:0]  win_pixel_8,
  input  logic [PIX_W-1:0]  win_pixel_9,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  pixel_count
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAP - 1);

  logic [NTAP-1:0][COEF_W-1:0] kin, kern_q;
  logic [NTAP-1:0][PIX_W-1:0]  win, win_q;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [PIX_W-1:0]   out_pix_q, out_pix_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               kern_ld, win_ld, mac_clr, mac_en;
  logic signed [ACC_W-1:0] acc, acc_nxt;

  assign kin = {k_pixel_9, k_pixel_8, k_pixel_7, k_pixel_6, k_pixel_5,
                k_pixel_4, k_pixel_3, k_pixel_2, k_pixel_1};
  assign win = {win_pixel_9, win_pixel_8, win_pixel_7, win_pixel_6, win_pixel_5,
                win_pixel_4, win_pixel_3, win_pixel_2, win_pixel_1};

  conv_tap_mac #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (mac_clr),
    .en_i      (mac_en),
    .tap_i     (tap_q),
    .win_i     (win_q),
    .kern_i    (kern_q),
    .acc_o     (acc),
    .acc_nxt_o (acc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    out_pix_d = out_pix_q;
    cnt_d     = cnt_q;
    kern_ld   = 1'b0;
    win_ld    = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stage3_start) begin
          kern_ld = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        // a reload on the accept edge lands in kern_q before tap 0 is used
        kern_ld = stage3_start;
        if (in_valid) begin
          win_ld  = 1'b1;
          mac_clr = 1'b1;
          tap_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        tap_d  = tap_q + 1'b1;
        if (tap_q == LAST_TAP) begin
          // clamp the sum including this cycle's product
          out_pix_d = PIX_W'(clamp_pix(acc_t'(acc_nxt)));
          tap_d     = '0;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      out_pix_q <= '0;
      cnt_q     <= '0;
      kern_q    <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      out_pix_q <= out_pix_d;
      cnt_q     <= cnt_d;
      if (kern_ld) kern_q <= kin;
      if (win_ld)  win_q  <= win;
    end
  end

  assign in_ready    = (state_q == READY);
  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q == MAC) || (state_q == OUT);
  assign out_pixel   = out_pix_q;
  assign pixel_count = cnt_q;

  logic unused_acc;
  assign unused_acc = ^acc;

endmodule

// File: tb/tb_conv_mac_stage3.sv
module tb_conv_mac_stage3;

  logic              clk = 1'b0;
  logic              rst, stage3_start, in_valid, out_ready;
  logic signed [3:0] k [9];
  logic [7:0]        w [9];
  logic              in_ready, out_valid, busy;
  logic [7:0]        out_pixel;
  logic [15:0]       pixel_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  conv_mac_stage3 dut (
    .clk(clk), .rst(rst), .stage3_start(stage3_start),
    .k_pixel_1(k[0]), .k_pixel_2(k[1]), .k_pixel_3(k[2]),
    .k_pixel_4(k[3]), .k_pixel_5(k[4]), .k_pixel_6(k[5]),
    .k_pixel_7(k[6]), .k_pixel_8(k[7]), .k_pixel_9(k[8]),
    .win_pixel_1(w[0]), .win_pixel_2(w[1]), .win_pixel_3(w[2]),
    .win_pixel_4(w[3]), .win_pixel_5(w[4]), .win_pixel_6(w[5]),
    .win_pixel_7(w[6]), .win_pixel_8(w[7]), .win_pixel_9(w[8]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .pixel_count(pixel_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lap();
    for (int i = 0; i < 9; i++) k[i] = 4'sd0;
    k[1] = -4'sd1; k[3] = -4'sd1; k[5] = -4'sd1; k[7] = -4'sd1; k[4] = 4'sd4;
  endtask

  task automatic set_ones();
    for (int i = 0; i < 9; i++) k[i] = 4'sd1;
  endtask

  task automatic set_win(input logic [7:0] c, input logic [7:0] n);
    for (int i = 0; i < 9; i++) w[i] = n;
    w[4] = c;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  in_ready,    0);
    check({tag, "_out_valid"}, out_valid,   0);
    check({tag, "_busy"},      busy,        0);
    check({tag, "_out_pixel"}, out_pixel,   0);
    check({tag, "_count"},     pixel_count, 0);
  endtask

  // One window: accept, 9 MAC cycles, result check, optional backpressure,
  // optional same-edge kernel reload, optional start poke during MAC.
  task automatic run_window(input string tag, input logic [7:0] c, input logic [7:0] n,
                            input logic [7:0] exp, input bit bp, input bit reload,
                            input bit poke);
    bit early, stable;
    logic signed [3:0] ksave [9];
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    check({tag, "_wait_ready"}, in_ready, 1);
    set_win(c, n);
    out_ready    = !bp;
    in_valid     = 1'b1;
    stage3_start = reload;
    step();
    in_valid     = 1'b0;
    stage3_start = 1'b0;
    check({tag, "_busy_mac"}, {in_ready, busy}, 2'b01);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (poke && i == 3) begin
        ksave = k;
        for (int j = 0; j < 9; j++) k[j] = 4'sd7;
        stage3_start = 1'b1;
      end
      step();
      if (poke && i == 3) begin
        stage3_start = 1'b0;
        k = ksave;
      end
      if (out_valid) early = 1'b1;
    end
    check({tag, "_no_early_valid"}, early, 0);
    step();
    check({tag, "_valid_lat9"}, out_valid, 1);
    check({tag, "_pixel"}, out_pixel, exp);
    check({tag, "_in_ready_out"}, in_ready, 0);
    if (bp) begin
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step();
        if (!out_valid || out_pixel !== exp || in_ready || !busy) stable = 1'b0;
      end
      check({tag, "_bp_stable"}, stable, 1);
      check({tag, "_bp_count"}, pixel_count, 16'(exp_cnt));
      out_ready = 1'b1;
    end
    step();
    exp_cnt++;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_ready"}, in_ready, 1);
    check({tag, "_count"}, pixel_count, 16'(exp_cnt));
  endtask

  initial begin
    bit bad;
    logic [7:0] exp_neg;
    rst = 1'b1; stage3_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin k[i] = 4'sd0; w[i] = 8'd0; end
    step(); step();
    check_reset("reset");
    rst = 1'b0;

    // window before any kernel load is ignored
    set_win(100, 100);
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (in_ready || out_valid || busy) bad = 1'b1;
    end
    in_valid = 1'b0;
    check("idle_ignore", bad, 0);
    check("idle_count", pixel_count, 0);

    // load Laplacian kernel
    set_lap();
    stage3_start = 1'b1;
    step();
    stage3_start = 1'b0;
    check("load_ready", in_ready, 1);

    run_window("flat",   100, 100, 8'd0,   0, 0, 0);
    run_window("sat_hi", 200, 100, 8'd255, 0, 0, 0);
    run_window("mid",    50,  20,  8'd120, 0, 0, 0);
`ifdef CONV_ABS_EN
    exp_neg = 8'd200;
`else
    exp_neg = 8'd0;
`endif
    run_window("neg",    0,   50,  exp_neg, 0, 0, 0);
    run_window("bp",     200, 100, 8'd255, 1, 0, 0);
    // kernel reload during MAC must not affect the running window
    run_window("mac_poke", 50, 20, 8'd120, 0, 0, 1);

    // reload on the accept edge: all-ones kernel, flat 20 -> 180
    set_ones();
    run_window("reload_accept", 20, 20, 8'd180, 0, 1, 0);
    // clamp boundaries with all-ones kernel: 255 exact, 256 saturates
    run_window("b255", 255, 0,  8'd255, 0, 0, 0);
    run_window("b256", 0,   32, 8'd255, 0, 0, 0);
    run_window("b252", 28,  28, 8'd252, 0, 0, 0);

    // reset in the middle of MAC (tap 4)
    set_lap();
    set_win(50, 20);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    check_reset("mid_rst");
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (in_ready || busy) bad = 1'b1;
    end
    in_valid = 1'b0;
    check("rst_idle", bad, 0);
    stage3_start = 1'b1;
    step();
    stage3_start = 1'b0;
    run_window("after_rst", 50, 20, 8'd120, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
